dds_multi_ch: RTL and testbench

Parametrised multi-channel direct digital synthesiser. It generates NCH independent signed sine outputs from per-channel phase accumulators and a quarter-wave sine LUT. Frequency and phase words are written into shadow registers and applied to all channels at once on a commit strobe, so channels stay phase-coherent. It sits in the signal-generation path, between the control register bank and the DAC / modulator datapath.

---
 rtl/dds_pkg.sv | 43 ++++
 rtl/dds_qlut.sv | 38 +++
 rtl/dds_multi_ch.sv | 112 +++++++++++
 tb/tb_dds_multi_ch.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS: default geometry, config
// select encoding, quadrant encoding and the quarter-wave table generator.
package dds_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 11;
    localparam int LUT_AW     = ADDR_W_DEF - 2;
    localparam int MAG_W      = DATA_W_DEF - 1;

    localparam logic SEL_FWORD = 1'b0;
    localparam logic SEL_PWORD = 1'b1;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    localparam real HALF_PI = 1.5707963267948966;

    // Odd Taylor series; accurate far beyond table precision on [0, pi/2].
    function automatic real sin_approx(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic int lut_entry(input int i, input int aw, input int mw);
        real amp;
        real ang;
        amp = real'((32'sd1 <<< mw) - 32'sd1);
        ang = HALF_PI * (real'(i) + 0.5) / real'(32'sd1 <<< aw);
        return $rtoi(amp * sin_approx(ang) + 0.5);
    endfunction

endpackage

// File: rtl/dds_qlut.sv
// Quarter-wave sine ROM, one-cycle synchronous read, generated at elaboration.
module dds_qlut
    import dds_pkg::*;
#(
    parameter int AW = LUT_AW,
    parameter int DW = MAG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ce,
    input  logic          i_clr,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0] w_rom [1 << AW];
    logic [DW-1:0] r_data;

    for (genvar i = 0; i < (1 << AW); i++) begin : g_rom
        assign w_rom[i] = DW'(lut_entry(i, AW, DW));
    end

    // Registered table read with synchronous clear for idle channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (i_clr) begin
            r_data <= '0;
        end else if (i_ce) begin
            r_data <= w_rom[i_addr];
        end else begin
            r_data <= r_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/dds_multi_ch.sv
// Multi-channel DDS: shadowed frequency/phase words committed atomically,
// per-channel accumulator feeding a 3-stage quarter-wave sine pipeline.
module dds_multi_ch
    import dds_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = LUT_AW + 2,
    parameter int DATA_W  = MAG_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        ch_en,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_ch,
    input  logic                  cfg_sel,
    input  logic [PHASE_W-1:0]    cfg_data,
    input  logic                  cfg_commit,
    input  logic [NCH-1:0]        commit_phase_rst,
    output logic [NCH*DATA_W-1:0] dds_out,
    output logic [NCH-1:0]        dds_valid
);

    localparam int LAW = ADDR_W - 2;
    localparam int MW  = DATA_W - 1;

    logic [PHASE_W-1:0] r_sh_fw [NCH];
    logic [ADDR_W-1:0]  r_sh_pw [NCH];
    logic [PHASE_W-1:0] r_fw    [NCH];
    logic [ADDR_W-1:0]  r_pw    [NCH];

    // Commit copies the pre-write shadow, so a coinciding write waits for the next commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_fw <= '{default: '0};
            r_sh_pw <= '{default: '0};
            r_fw    <= '{default: '0};
            r_pw    <= '{default: '0};
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (cfg_commit) begin
                    r_fw[c] <= r_sh_fw[c];
                    r_pw[c] <= r_sh_pw[c];
                end
                if (cfg_we && (cfg_ch == 4'(c))) begin
                    case (cfg_sel)
                        SEL_FWORD: r_sh_fw[c] <= cfg_data;
                        SEL_PWORD: r_sh_pw[c] <= cfg_data[ADDR_W-1:0];
                        default:   r_sh_fw[c] <= r_sh_fw[c];
                    endcase
                end
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [PHASE_W-1:0]       r_acc;
        logic [LAW-1:0]           r_idx;
        quad_e                    r_q;
        logic                     r_neg;
        logic signed [DATA_W-1:0] r_out;
        logic [2:0]               r_vld;
        logic [ADDR_W-1:0]        w_a;
        logic [MW-1:0]            w_mag;
        logic signed [DATA_W-1:0] w_mag_ext;

        assign w_a       = r_acc[PHASE_W-1 -: ADDR_W] + r_pw[c];
        assign w_mag_ext = {1'b0, w_mag};

        // Odd quadrants mirror the table index; the upper half negates the magnitude.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_acc <= '0;
                r_idx <= '0;
                r_q   <= QUAD_0;
                r_neg <= 1'b0;
                r_out <= '0;
                r_vld <= 3'b000;
            end else if (!ch_en[c]) begin
                r_acc <= '0;
                r_idx <= '0;
                r_q   <= QUAD_0;
                r_neg <= 1'b0;
                r_out <= '0;
                r_vld <= 3'b000;
            end else begin
                r_acc <= (cfg_commit && commit_phase_rst[c]) ? '0 : r_acc + r_fw[c];
                r_q   <= quad_e'(w_a[ADDR_W-1 -: 2]);
                r_idx <= w_a[ADDR_W-2] ? ~w_a[LAW-1:0] : w_a[LAW-1:0];
                r_neg <= r_q[1];
                r_out <= r_neg ? -w_mag_ext : w_mag_ext;
                r_vld <= {r_vld[1:0], 1'b1};
            end
        end

        dds_qlut #(
            .AW(LAW),
            .DW(MW)
        ) u_qlut (
            .clk   (clk),
            .rst   (rst),
            .i_ce  (ch_en[c]),
            .i_clr (~ch_en[c]),
            .i_addr(r_idx),
            .o_data(w_mag)
        );

        assign dds_out[c*DATA_W +: DATA_W] = r_out;
        assign dds_valid[c]                = r_vld[2];
    end

endmodule

// File: tb/tb_dds_multi_ch.sv
// Self-checking bench for dds_multi_ch against an ideal-sine phase model.
module tb_dds_multi_ch;

    localparam int NCH = 4;
    localparam int PW  = 32;
    localparam int AW  = 11;
    localparam int DW  = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  ch_en;
    logic            cfg_we;
    logic [3:0]      cfg_ch;
    logic            cfg_sel;
    logic [PW-1:0]   cfg_data;
    logic            cfg_commit;
    logic [NCH-1:0]  commit_phase_rst;
    logic [NCH*DW-1:0] dds_out;
    logic [NCH-1:0]  dds_valid;

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0] m_shf [NCH];
    logic [AW-1:0] m_shp [NCH];
    logic [PW-1:0] m_acf [NCH];
    logic [AW-1:0] m_acp [NCH];
    logic [PW-1:0] m_acc [NCH];
    int            m_ph1 [NCH];
    int            m_ph2 [NCH];
    int            m_run [NCH];
    int            m_exp [NCH];

    dds_multi_ch #(.NCH(NCH), .PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .commit_phase_rst(commit_phase_rst), .dds_out(dds_out), .dds_valid(dds_valid)
    );

    always #5 clk = ~clk;

    // Ideal rounded sine at the centre of phase step a of a 2^AW-step cycle.
    function automatic int sine_ref(input int a);
        real x;
        x = 1023.0 * $sin(2.0 * 3.14159265358979 * (real'(a) + 0.5) / 2048.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic logic signed [DW-1:0] dut_ch(input int c);
        return dds_out[c*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_shf[c] = '0; m_shp[c] = '0; m_acf[c] = '0; m_acp[c] = '0;
            m_acc[c] = '0; m_ph1[c] = 0; m_ph2[c] = 0; m_run[c] = 0; m_exp[c] = 0;
        end
    endtask

    // Advance the model by one clock edge from the current inputs, then clock the DUT.
    task automatic tick();
        for (int c = 0; c < NCH; c++) begin
            if (!ch_en[c]) begin
                m_acc[c] = '0; m_ph1[c] = 0; m_ph2[c] = 0; m_run[c] = 0; m_exp[c] = 0;
            end else begin
                m_exp[c] = sine_ref(m_ph2[c]);
                m_ph2[c] = m_ph1[c];
                m_ph1[c] = (int'(m_acc[c] >> (PW - AW)) + int'(m_acp[c])) % 2048;
                m_acc[c] = (cfg_commit && commit_phase_rst[c]) ? '0 : m_acc[c] + m_acf[c];
                if (m_run[c] < 3) m_run[c]++;
            end
        end
        if (cfg_commit) begin
            for (int c = 0; c < NCH; c++) begin
                m_acf[c] = m_shf[c];
                m_acp[c] = m_shp[c];
            end
        end
        if (cfg_we && int'(cfg_ch) < NCH) begin
            if (cfg_sel) m_shp[cfg_ch] = cfg_data[AW-1:0];
            else         m_shf[cfg_ch] = cfg_data;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_cfg(input int ch, input logic sel, input logic [PW-1:0] data);
        cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_sel = sel; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 1'b0;
        cfg_data = '0; cfg_commit = 1'b0; commit_phase_rst = '0;
        model_reset();
        #23;
        checks++;
        if (dds_out !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", dds_out); end
        checks++;
        if (dds_valid !== '0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dds_valid); end
        @(negedge clk); rst = 1'b1;
        write_cfg(0, 1'b0, 32'h0020_0000);
        for (int n = 0; n < 12; n++) begin
            if (n == 4) ch_en = 4'b0001;
            tick();
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (dds_valid[c] !== (m_run[c] == 3)) begin
                    failures++; $display("FAIL idle_valid ch%0d got=%b exp=%0d", c, dds_valid[c], m_run[c] == 3);
                end
                if (m_run[c] == 0 || m_run[c] == 3) begin
                    checks++;
                    if (dut_ch(c) !== DW'(m_exp[c])) begin
                        failures++; $display("FAIL idle_out ch%0d got=%0d exp=%0d", c, dut_ch(c), m_exp[c]);
                    end
                end
            end
        end
        ch_en = '0;
        tick();
    endtask

    task automatic test_basic_tone();
        int lat, mx, mn, first;
        lat = -1; mx = -5000; mn = 5000; first = -5000;
        write_cfg(0, 1'b1, 32'h0);
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        ch_en = 4'b0001;
        for (int n = 1; n <= 2100; n++) begin
            tick();
            if (dds_valid[0] === 1'b1) begin
                if (lat < 0) begin lat = n; first = dut_ch(0); end
                if (dut_ch(0) > mx) mx = dut_ch(0);
                if (dut_ch(0) < mn) mn = dut_ch(0);
            end
            checks++;
            if (dds_valid[0] !== (m_run[0] == 3)) begin
                failures++; $display("FAIL tone_valid n=%0d got=%b", n, dds_valid[0]);
            end
            if (m_run[0] == 3) begin
                checks++;
                if (dut_ch(0) !== DW'(m_exp[0])) begin
                    failures++; $display("FAIL tone_out n=%0d got=%0d exp=%0d", n, dut_ch(0), m_exp[0]);
                end
            end
        end
        checks++;
        if (lat != 3) begin failures++; $display("FAIL tone_latency got=%0d exp=3", lat); end
        checks++;
        if (first != sine_ref(0)) begin failures++; $display("FAIL tone_first got=%0d exp=%0d", first, sine_ref(0)); end
        checks++;
        if (mx != 1023 || mn != -1023) begin
            failures++; $display("FAIL tone_peaks got=%0d/%0d exp=1023/-1023", mx, mn);
        end
    endtask

    task automatic test_phase_offset();
        int s0 [1100];
        int s1 [1100];
        int bad;
        bad = 0;
        write_cfg(1, 1'b0, 32'h0020_0000);
        write_cfg(1, 1'b1, 32'd512);
        ch_en = 4'b0011;
        tick();
        cfg_commit = 1'b1; commit_phase_rst = 4'b0011;
        tick();
        cfg_commit = 1'b0; commit_phase_rst = '0;
        for (int n = 0; n < 1100; n++) begin
            tick();
            s0[n] = dut_ch(0);
            s1[n] = dut_ch(1);
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (m_run[c] == 3 && (dut_ch(c) !== DW'(m_exp[c]) || dds_valid[c] !== 1'b1)) begin
                    failures++; $display("FAIL phase_out ch%0d n=%0d got=%0d exp=%0d", c, n, dut_ch(c), m_exp[c]);
                end
            end
        end
        for (int n = 2; n < 580; n++) begin
            if (s1[n] != s0[n + 512]) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL phase_relation mismatched=%0d exp=0", bad); end
    endtask

    task automatic test_atomic_commit();
        ch_en = 4'b1111;
        for (int c = 0; c < NCH; c++) write_cfg(c, 1'b0, $urandom);
        for (int n = 0; n < 40; n++) begin
            if (n == 10) begin
                cfg_commit = 1'b1; cfg_we = 1'b1; cfg_ch = 4'd2; cfg_sel = 1'b0; cfg_data = $urandom;
            end
            if (n == 25) cfg_commit = 1'b1;
            tick();
            cfg_commit = 1'b0; cfg_we = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (dds_valid[c] !== (m_run[c] == 3) || (m_run[c] == 3 && dut_ch(c) !== DW'(m_exp[c]))) begin
                    failures++; $display("FAIL atomic ch%0d n=%0d got=%0d exp=%0d", c, n, dut_ch(c), m_exp[c]);
                end
            end
        end
    endtask

    task automatic test_enable_midrun();
        for (int n = 0; n < 20; n++) begin
            if (n == 3) ch_en[2] = 1'b0;
            if (n == 8) ch_en[2] = 1'b1;
            tick();
            if (n == 3) begin
                checks++;
                if (dut_ch(2) !== '0 || dds_valid[2] !== 1'b0) begin
                    failures++; $display("FAIL en_drop got=%0d/%b exp=0/0", dut_ch(2), dds_valid[2]);
                end
            end
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (dds_valid[c] !== (m_run[c] == 3)) begin
                    failures++; $display("FAIL en_valid ch%0d n=%0d got=%b", c, n, dds_valid[c]);
                end
                if (m_run[c] == 0 || m_run[c] == 3) begin
                    checks++;
                    if (dut_ch(c) !== DW'(m_exp[c])) begin
                        failures++; $display("FAIL en_out ch%0d n=%0d got=%0d exp=%0d", c, n, dut_ch(c), m_exp[c]);
                    end
                end
            end
        end
    endtask

    task automatic test_boundaries();
        write_cfg(7, 1'b0, 32'h1234_5678);
        write_cfg(7, 1'b1, 32'h0000_0155);
        write_cfg(3, 1'b0, 32'hFFFF_FFFF);
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            checks++;
            if ($isunknown(dds_out) || $isunknown(dds_valid)) begin
                failures++; $display("FAIL bound_x got=%h", dds_out);
            end
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (m_run[c] == 3 && dut_ch(c) !== DW'(m_exp[c])) begin
                    failures++; $display("FAIL bound_out ch%0d n=%0d got=%0d exp=%0d", c, n, dut_ch(c), m_exp[c]);
                end
            end
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dds_out !== '0 || dds_valid !== '0) begin
            failures++; $display("FAIL async_rst got=%h/%b exp=0/0", dds_out, dds_valid);
        end
        model_reset();
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            cfg_we = 1'($urandom); cfg_ch = 4'($urandom_range(0, 7)); cfg_sel = 1'($urandom);
            cfg_data = $urandom; cfg_commit = ($urandom_range(0, 7) == 0);
            commit_phase_rst = 4'($urandom);
            if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom);
            tick();
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (dds_valid[c] !== (m_run[c] == 3)) begin
                    failures++; $display("FAIL rand_valid ch%0d n=%0d got=%b", c, n, dds_valid[c]);
                end
                if (m_run[c] == 0 || m_run[c] == 3) begin
                    checks++;
                    if (dut_ch(c) !== DW'(m_exp[c])) begin
                        failures++; $display("FAIL rand_out ch%0d n=%0d got=%0d exp=%0d", c, n, dut_ch(c), m_exp[c]);
                    end
                end
            end
        end
        cfg_we = 1'b0; cfg_commit = 1'b0; commit_phase_rst = '0;
    endtask

    initial begin
        test_reset();
        test_basic_tone();
        test_phase_offset();
        test_atomic_commit();
        test_enable_midrun();
        test_boundaries();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
